// File: rtl/gf180mcu_fd_sc_mcu9t5v0__syncfilt_pkg.sv
// Shared types and helpers for the synchronising glitch filter.
// State encoding and counter width calculation.
package gf180mcu_fd_sc_mcu9t5v0__syncfilt_pkg;

   typedef enum logic {
      STABLE  = 1'b0,
      QUALIFY = 1'b1
   } state_e;

   // Bits needed to hold values 0..v-1; bounded loop keeps it elaboration-safe.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int k = 0; k < 16; k++) begin
         if ((1 << k) < v) r = k + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sync_chain.sv
// Flop chain bringing an asynchronous level into the clock domain.
// Every stage resets asynchronously to RST_VAL.
module gf180mcu_fd_sc_mcu9t5v0__sync_chain #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   assign sync_d = {sync_q[STAGES-2:0], d_i};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= {STAGES{RST_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__syncfilt_4.sv
// Synchronising glitch filter feeding the x4 buffer stage.
// A level change must persist FILT_CYCLES clocks before reaching Z.
module gf180mcu_fd_sc_mcu9t5v0__syncfilt_4
   import gf180mcu_fd_sc_mcu9t5v0__syncfilt_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter int   FILT_CYCLES = 4,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic CLK,
   input  logic RST,
   input  logic I,
   input  logic EN,
   output logic Z,
   output logic ZP,
   inout  wire  VDD,
   inout  wire  VSS
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("SYNC_STAGES out of range 2..4");
   end
   if (FILT_CYCLES < 1 || FILT_CYCLES > 255) begin : g_bad_filt
      $error("FILT_CYCLES out of range 1..255");
   end

   localparam int CW = clog2(FILT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(FILT_CYCLES - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   wire unused_pwr = VDD ^ VSS;

   logic s;

   gf180mcu_fd_sc_mcu9t5v0__sync_chain #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (RST_VAL)
   ) u_sync (
      .clk_i (CLK),
      .rst_i (RST),
      .d_i   (I),
      .q_o   (s)
   );

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          z_q, z_d;
   logic          zp_q, zp_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      z_d     = z_q;
      zp_d    = 1'b0;
      if (EN) begin
         unique case (state_q)
            STABLE: begin
               if (s != z_q) begin
                  if (FILT_CYCLES == 1) begin
                     z_d  = s;
                     zp_d = 1'b1;
                  end else begin
                     state_d = QUALIFY;
                     cnt_d   = ONE;
                  end
               end
            end
            QUALIFY: begin
               if (s == z_q) begin
                  // Level fell back before qualifying: drop it.
                  state_d = STABLE;
                  cnt_d   = '0;
               end else if (cnt_q == LAST) begin
                  z_d     = s;
                  zp_d    = 1'b1;
                  cnt_d   = '0;
                  state_d = STABLE;
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
            default: begin
               state_d = STABLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= STABLE;
         cnt_q   <= '0;
         z_q     <= RST_VAL;
         zp_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         z_q     <= z_d;
         zp_q    <= zp_d;
      end
   end

   assign Z  = z_q;
   assign ZP = zp_q;

endmodule
